xuart_tx: RTL and testbench

Memory-mapped UART transmitter on the external parallel data bus (par_addr/par_out/par_we/par_re, qualified by the address decoder's external select).
- Software writes bytes into an 8-entry FIFO.
- A baud-rate counter and frame state machine serialise each byte to the txd pin as 8N1.
- Status and divisor registers are readable over the same bus.

---
 rtl/xuart_tx_if.sv | 26 ++
 rtl/xuart_tx.sv | 195 +++++++++++++++++++
 tb/tb_xuart_tx.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/xuart_tx_if.sv
// xuart_tx_if: parallel register bus between the address decoder/CPU side and
// the UART transmitter.
//   sel      - block select from the external address decoder
//   we       - write strobe (qualified by sel)
//   addr     - register address
//   data_in  - write data
//   data_out - read data (combinational in the slave)
interface xuart_tx_if #(
  parameter int unsigned DATA_W = 32
);
  logic              sel;
  logic              we;
  logic [1:0]        addr;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;

  modport master (
    output sel, we, addr, data_in,
    input  data_out
  );

  modport slave (
    input  sel, we, addr, data_in,
    output data_out
  );
endinterface

// File: rtl/xuart_tx.sv
// xuart_tx: memory-mapped 8N1 UART transmitter with an 8-entry byte FIFO.
//   clk  - system clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - register bus (slave): addr 0 TXDATA/count, 1 DIV, 2 STATUS, 3 reserved
//   txd  - serial output, idle high
module xuart_tx #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned FIFO_AW = 3,
  parameter int unsigned DIV_W   = 16,
  parameter int unsigned DIV_RST = 434
) (
  input  logic         clk,
  input  logic         rst,
  xuart_tx_if.slave    bus,
  output logic         txd
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned CNT_W = FIFO_AW + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  localparam logic [1:0] A_TXDATA = 2'd0;
  localparam logic [1:0] A_DIV    = 2'd1;
  localparam logic [1:0] A_STATUS = 2'd2;

  // FIFO storage and bookkeeping
  logic [7:0]         fifo_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q,  count_d;
  logic               ovf_q,    ovf_d;

  // Configuration
  logic [DIV_W-1:0]   div_q,    div_d;

  // Frame engine
  logic [1:0]         state_q,  state_d;
  logic [DIV_W-1:0]   baud_q,   baud_d;
  logic [2:0]         bit_idx_q, bit_idx_d;
  logic [7:0]         shift_q,  shift_d;
  logic               txd_q,    txd_d;

  logic wr_en_c;
  logic push_req_c;
  logic push_c;
  logic pop_c;
  logic full_c;
  logic empty_c;
  logic busy_c;
  logic unused_data_bits;

  assign unused_data_bits = ^bus.data_in[DATA_W-1:DIV_W];

  assign wr_en_c    = bus.sel & bus.we;
  assign push_req_c = wr_en_c & (bus.addr == A_TXDATA);
  assign full_c     = (count_q == CNT_W'(DEPTH));
  assign empty_c    = (count_q == CNT_W'(0));
  assign busy_c     = (state_q != ST_IDLE);
  // Full is judged on the pre-edge count; a same-cycle pop does not rescue it.
  assign push_c     = push_req_c & ~full_c;

  // FIFO pointer/count/overflow and divisor next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    div_d    = div_q;
    ovf_d    = ovf_q;

    if (push_c) wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
    if (pop_c)  rd_ptr_d = rd_ptr_q + FIFO_AW'(1);

    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (wr_en_c && (bus.addr == A_DIV)) div_d = bus.data_in[DIV_W-1:0];

    // A dropped push in the same cycle as a STATUS-write clear leaves overflow set.
    if (wr_en_c && (bus.addr == A_STATUS)) ovf_d = 1'b0;
    if (push_req_c && full_c)              ovf_d = 1'b1;
  end

  // Frame state machine: next state, baud counter, shift register, pop
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop_c     = 1'b0;
    txd_d     = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (!empty_c) begin
          pop_c   = 1'b1;
          shift_d = fifo_q[rd_ptr_q];
          baud_d  = div_q;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (baud_q == DIV_W'(0)) begin
          baud_d    = div_q;
          bit_idx_d = 3'd0;
          state_d   = ST_DATA;
        end else begin
          baud_d = baud_q - DIV_W'(1);
        end
      end
      ST_DATA: begin
        if (baud_q == DIV_W'(0)) begin
          shift_d = {1'b0, shift_q[7:1]};
          baud_d  = div_q;
          if (bit_idx_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          baud_d = baud_q - DIV_W'(1);
        end
      end
      ST_STOP: begin
        if (baud_q == DIV_W'(0)) begin
          state_d = ST_IDLE;
        end else begin
          baud_d = baud_q - DIV_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // txd is registered from the state being entered so the pin is glitch-free.
    case (state_d)
      ST_START: txd_d = 1'b0;
      ST_DATA:  txd_d = shift_d[0];
      default:  txd_d = 1'b1;
    endcase
  end

  // FIFO storage write (no reset needed; validity tracked by count)
  always_ff @(posedge clk) begin
    if (push_c) fifo_q[wr_ptr_q] <= bus.data_in[7:0];
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      div_q     <= DIV_W'(DIV_RST);
      state_q   <= ST_IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      txd_q     <= 1'b1;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      div_q     <= div_d;
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      txd_q     <= txd_d;
    end
  end

  // Register read mux
  always_comb begin
    bus.data_out = '0;
    if (bus.sel && !bus.we) begin
      case (bus.addr)
        A_TXDATA: bus.data_out = DATA_W'(count_q);
        A_DIV:    bus.data_out = DATA_W'(div_q);
        A_STATUS: bus.data_out = DATA_W'({ovf_q, empty_c, full_c, busy_c});
        default:  bus.data_out = '0;
      endcase
    end
  end

  assign txd = txd_q;

endmodule

// File: tb/tb_xuart_tx.sv
// tb_xuart_tx: directed bench for xuart_tx with a byte scoreboard; expected
// bytes are queued on write and checked bit-by-bit against txd.
module tb_xuart_tx;

  logic clk = 1'b0;
  logic rst;
  logic txd;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q [$];

  xuart_tx_if #(.DATA_W(32)) bus ();

  xuart_tx #(
    .DATA_W (32),
    .FIFO_AW(3),
    .DIV_W  (16),
    .DIV_RST(434)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .txd(txd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Call at a negedge; the write lands on the following posedge.
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    bus.sel     = 1'b1;
    bus.we      = 1'b1;
    bus.addr    = a;
    bus.data_in = d;
    @(negedge clk);
    bus.sel = 1'b0;
    bus.we  = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    bus.sel  = 1'b1;
    bus.we   = 1'b0;
    bus.addr = a;
    #1;
    d = bus.data_out;
  endtask

  task automatic push_byte(input logic [7:0] d, input bit accept);
    bus_write(2'd0, {24'd0, d});
    if (accept) exp_q.push_back(d);
  endtask

  // Receive one frame: bits before chg_bit last div_a+1 cycles, the rest div_b+1.
  // Optionally writes DIV=mid_div at frame cycle mid_cyc.
  task automatic rx_frame(input int div_a, input int div_b, input int chg_bit,
                          input int max_wait, input bit chk_busy,
                          input int mid_cyc, input int mid_div);
    logic [7:0] b;
    logic       eb;
    int         w;
    int         g;
    int         len;
    check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
    b = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
    if (chk_busy) begin
      bus.sel  = 1'b1;
      bus.we   = 1'b0;
      bus.addr = 2'd2;
    end
    #1;
    w = 0;
    while (txd !== 1'b0 && w < max_wait) begin
      @(negedge clk);
      w++;
    end
    check("start_seen", 32'(txd), 32'd0);
    g = 0;
    for (int k = 0; k < 10; k++) begin
      if (k == 0)      eb = 1'b0;
      else if (k == 9) eb = 1'b1;
      else             eb = b[k-1];
      len = (k < chg_bit) ? div_a + 1 : div_b + 1;
      for (int c = 0; c < len; c++) begin
        check($sformatf("byte%02h_bit%0d_cyc%0d", b, k, c), 32'(txd), 32'(eb));
        if (chk_busy) check($sformatf("busy_bit%0d", k), 32'(bus.data_out[0]), 32'd1);
        if (g == mid_cyc) begin
          bus.sel     = 1'b1;
          bus.we      = 1'b1;
          bus.addr    = 2'd1;
          bus.data_in = 32'(mid_div);
        end else if (g == mid_cyc + 1) begin
          bus.sel = 1'b0;
          bus.we  = 1'b0;
        end
        @(negedge clk);
        g++;
      end
    end
    check("idle_after_stop", 32'(txd), 32'd1);
    if (chk_busy) check("busy_fall", 32'(bus.data_out[0]), 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    int lows;

    rst         = 1'b1;
    bus.sel     = 1'b0;
    bus.we      = 1'b0;
    bus.addr    = 2'd0;
    bus.data_in = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    bus_read(2'd2, rd); check("rst_status", rd, 32'h4);
    bus_read(2'd1, rd); check("rst_div", rd, 32'd434);
    bus_read(2'd0, rd); check("rst_count", rd, 32'd0);
    bus_read(2'd3, rd); check("addr3_read", rd, 32'd0);
    check("rst_txd", 32'(txd), 32'd1);
    @(negedge clk);

    // DIV=3, single 0x55 frame
    bus_write(2'd1, 32'd3);
    bus_read(2'd1, rd); check("div3_read", rd, 32'd3);
    @(negedge clk);
    push_byte(8'h55, 1'b1);
    rx_frame(3, 3, 10, 4, 1'b1, -10, 0);
    @(negedge clk);

    // DIV=1, back-to-back 0x01 then 0x80
    bus_write(2'd1, 32'd1);
    push_byte(8'h01, 1'b1);
    push_byte(8'h80, 1'b1);
    rx_frame(1, 1, 10, 4, 1'b1, -10, 0);
    rx_frame(1, 1, 10, 1, 1'b1, -10, 0);
    repeat (2) @(negedge clk);

    // DIV=7, rewrite DIV=1 in the middle of data bit 3
    bus_write(2'd1, 32'd7);
    push_byte(8'hA5, 1'b1);
    rx_frame(7, 1, 5, 4, 1'b0, 34, 1);
    bus_read(2'd1, rd); check("div_after_mid", rd, 32'd1);
    @(negedge clk);

    // DIV=100, fill FIFO, overflow and clear
    bus_write(2'd1, 32'd100);
    for (int i = 0; i < 9; i++) push_byte(8'h10 + 8'(i), 1'b1);
    bus_read(2'd0, rd); check("fifo_count_full", rd, 32'd8);
    bus_read(2'd2, rd); check("status_full", rd, 32'h3);
    @(negedge clk);
    push_byte(8'hEE, 1'b0);
    bus_read(2'd2, rd); check("status_ovf", rd, 32'hB);
    bus_read(2'd0, rd); check("count_after_drop", rd, 32'd8);
    @(negedge clk);
    bus_write(2'd2, 32'd0);
    bus_read(2'd2, rd); check("status_ovf_clr", rd, 32'h3);
    @(negedge clk);

    // Reset in the middle of data bit 0 of the first frame
    bus.sel = 1'b0;
    repeat (150) @(negedge clk);
    check("pre_rst_in_data", 32'(txd), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("txd_after_rst", 32'(txd), 32'd1);
    rst = 1'b0;
    exp_q.delete();
    bus_read(2'd2, rd); check("post_rst_status", rd, 32'h4);
    bus_read(2'd1, rd); check("post_rst_div", rd, 32'd434);
    bus_read(2'd0, rd); check("post_rst_count", rd, 32'd0);
    lows = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (txd !== 1'b1) lows++;
    end
    check("no_frame_after_rst", 32'(lows), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
